// File: rtl/cla64_share_ctrl_if.sv
// Request/response bundle between the requesters, the result consumer and the shared-adder scheduler.
interface cla64_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*64-1:0] req_a;
  logic [NREQ*64-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    req_chain;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [63:0]        resp_sum;
  logic               resp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_chain, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_chain, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );
endinterface

// File: rtl/cla64_share_ctrl.sv
// Round-robin scheduler sharing one combinational 64-bit KPG carry-lookahead adder among NREQ
// requesters, with per-requester carry flags for multi-word chained additions.
module cla64_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  cla64_share_ctrl_if.slave   bus,
  output logic [63:0]         add_a,
  output logic [63:0]         add_b,
  output logic [7:0]          add_xin,
  input  logic [63:0]         add_sum,
  input  logic [7:0]          add_xout,
  output logic [31:0]         op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  function automatic logic [7:0] enc_carry(input logic c);
    return c ? 8'h67 : 8'h6B;
  endfunction

  // Only an explicit "g" counts as a carry; "k", "p" and anything malformed decode to 0.
  function automatic logic dec_carry(input logic [7:0] x);
    return (x == 8'h67);
  endfunction

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q;
  logic [63:0]     a_q, b_q;
  logic [7:0]      xin_q;
  logic [IDW-1:0]  resp_id_q;
  logic [63:0]     resp_sum_q;
  logic            resp_cout_q;
  logic [NREQ-1:0] carry_flag_q;
  logic [31:0]     op_count_q;

  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            grant_en, xfer, accept;
  logic [63:0]     sel_a, sel_b;
  logic            sel_cin;

  // Search starts just after the last granted index.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any     = 1'b1;
        gnt_idx     = IDW'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

  assign grant_en = (state_q == IDLE) || ((state_q == DONE) && bus.resp_ready);
  assign xfer     = grant_en && gnt_any;
  assign accept   = (state_q == DONE) && bus.resp_ready;

  // A chained grant that coincides with the acceptance of the same requester's previous
  // result takes the carry straight from the result register, before the flag is updated.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        sel_a = bus.req_a[64*i +: 64];
        sel_b = bus.req_b[64*i +: 64];
        if (bus.req_chain[i])
          sel_cin = (accept && (resp_id_q == IDW'(i))) ? resp_cout_q : carry_flag_q[i];
        else
          sel_cin = bus.req_cin[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (bus.resp_ready) state_d = gnt_any ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= IDW'(NREQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      xin_q        <= 8'h6B;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
      carry_flag_q <= '0;
      op_count_q   <= '0;
    end else begin
      state_q <= state_d;
      // p0: operand capture on transfer
      if (xfer) begin
        ptr_q     <= gnt_idx;
        a_q       <= sel_a;
        b_q       <= sel_b;
        xin_q     <= enc_carry(sel_cin);
        resp_id_q <= gnt_idx;
      end
      // p1: adder result capture after one settling cycle
      if (state_q == EXEC) begin
        resp_sum_q  <= add_sum;
        resp_cout_q <= dec_carry(add_xout);
      end
      if (accept) begin
        carry_flag_q[resp_id_q] <= resp_cout_q;
        op_count_q              <= op_count_q + 32'd1;
      end
    end
  end

  assign bus.req_ready  = grant_en ? gnt_oh : '0;
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_cout  = resp_cout_q;
  assign add_a          = a_q;
  assign add_b          = b_q;
  assign add_xin        = xin_q;
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_cla64_share_ctrl.sv
// Directed bench for cla64_share_ctrl: vector table of single operations plus hand-written
// sequences for reset, round-robin, backpressure and carry bypass.
module tb_cla64_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] add_a, add_b, add_sum;
  logic [7:0]  add_xin, add_xout;
  logic [31:0] op_count;
  int          xmode = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  cla64_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  cla64_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .add_a(add_a), .add_b(add_b), .add_xin(add_xin),
    .add_sum(add_sum), .add_xout(add_xout), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference KPG adder; xmode forces the carry-out character to "p" (1) or "g" (2).
  always_comb begin
    logic [64:0] t;
    t = {1'b0, add_a} + {1'b0, add_b} + {64'd0, (add_xin == 8'h67)};
    add_sum  = t[63:0];
    add_xout = t[64] ? 8'h67 : 8'h6B;
    if (xmode == 1) add_xout = 8'h70;
    if (xmode == 2) add_xout = 8'h67;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        chain;
    int          xm;
    logic [63:0] sum;
    logic        cout;
    logic [7:0]  xin;
  } vec_t;

  vec_t vecs[12];

  task automatic clear_req();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.req_chain = '0;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    @(negedge clk);
    xmode = v.xm;
    clear_req();
    bus.req_valid[v.id]       = 1'b1;
    bus.req_a[64*v.id +: 64]  = v.a;
    bus.req_b[64*v.id +: 64]  = v.b;
    bus.req_cin[v.id]         = v.cin;
    bus.req_chain[v.id]       = v.chain;
    #1 chk($sformatf("v%0d_grant", k), 64'(bus.req_ready), 64'd1 << v.id);
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk($sformatf("v%0d_xin", k), 64'(add_xin), 64'(v.xin));
    @(posedge clk); #1;
    chk($sformatf("v%0d_rvalid", k), 64'(bus.resp_valid), 64'd1);
    chk($sformatf("v%0d_rid", k), 64'(bus.resp_id), 64'(v.id));
    chk($sformatf("v%0d_sum", k), bus.resp_sum, v.sum);
    chk($sformatf("v%0d_cout", k), 64'(bus.resp_cout), 64'(v.cout));
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    xmode = 0;
  endtask

  initial begin
    int ng;
    int gl[5];
    int gc[5];
    vecs[0]  = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 64'd0, 1'b1, 8'h6B};
    vecs[1]  = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 64'd0, 1'b1, 8'h6B};
    vecs[2]  = '{2, 64'd0, 64'd0, 1'b0, 1'b1, 0, 64'd1, 1'b0, 8'h67};
    vecs[3]  = '{1, 64'd5, 64'd7, 1'b1, 1'b0, 0, 64'd13, 1'b0, 8'h67};
    vecs[4]  = '{3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0, 64'd0, 1'b1, 8'h6B};
    vecs[5]  = '{3, 64'd1, 64'd2, 1'b0, 1'b1, 0, 64'd4, 1'b0, 8'h67};
    vecs[6]  = '{0, 64'd0, 64'd0, 1'b0, 1'b1, 0, 64'd1, 1'b0, 8'h67};
    vecs[7]  = '{1, 64'h1234, 64'h4321, 1'b0, 1'b0, 0, 64'h5555, 1'b0, 8'h6B};
    vecs[8]  = '{1, 64'd9, 64'd1, 1'b1, 1'b1, 0, 64'd10, 1'b0, 8'h6B};
    vecs[9]  = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1, 64'd0, 1'b0, 8'h6B};
    vecs[10] = '{0, 64'd1, 64'd1, 1'b0, 1'b0, 2, 64'd2, 1'b1, 8'h6B};
    vecs[11] = '{0, 64'd0, 64'd0, 1'b0, 1'b1, 0, 64'd1, 1'b0, 8'h67};

    clear_req();
    bus.resp_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rvalid", 64'(bus.resp_valid), 64'd0);
    chk("rst_rid", 64'(bus.resp_id), 64'd0);
    chk("rst_sum", bus.resp_sum, 64'd0);
    chk("rst_cout", 64'(bus.resp_cout), 64'd0);
    chk("rst_adda", add_a, 64'd0);
    chk("rst_addb", add_b, 64'd0);
    chk("rst_xin", 64'(add_xin), 64'h6B);
    chk("rst_opcnt", 64'(op_count), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) run_vec(vecs[k], k);
    chk("tbl_opcnt", 64'(op_count), 64'd12);

    // Asynchronous reset while the adder is settling
    @(negedge clk);
    bus.req_valid[3] = 1'b1;
    bus.req_a[64*3 +: 64] = 64'd5;
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("mid_adda", add_a, 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rvalid", 64'(bus.resp_valid), 64'd0);
    chk("mid_adda0", add_a, 64'd0);
    chk("mid_xin", 64'(add_xin), 64'h6B);
    chk("mid_opcnt", 64'(op_count), 64'd0);
    chk("mid_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_req();
    repeat (3) @(posedge clk);
    #1 chk("mid_noresp", 64'(bus.resp_valid), 64'd0);

    // All requesters busy: grants rotate 0,1,2,3,0 every two cycles
    @(negedge clk);
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) bus.req_a[64*i +: 64] = 64'(i + 1);
    bus.resp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gl[ng] = i;
        gc[ng] = c;
        ng++;
      end
      if (ng == 5) break;
      @(negedge clk);
    end
    if (ng < 5) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rr_timeout: got %0d grants required 5", ng);
    end else begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr_gnt%0d", k), 64'(gl[k]), 64'(k % NREQ));
        if (k > 0) chk($sformatf("rr_gap%0d", k), 64'(gc[k] - gc[k-1]), 64'd2);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rr_opcnt", 64'(op_count), 64'd5);
    chk("rr_idle", 64'(bus.resp_valid), 64'd0);
    bus.resp_ready = 1'b0;

    // Backpressure in DONE with a request pending
    @(negedge clk);
    clear_req();
    bus.req_valid[1] = 1'b1;
    bus.req_a[64*1 +: 64] = 64'd3;
    bus.req_b[64*1 +: 64] = 64'd4;
    #1 chk("bp_grant1", 64'(bus.req_ready), 64'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b1;
    bus.req_a[64*2 +: 64] = 64'd10;
    bus.req_b[64*2 +: 64] = 64'd20;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_rvalid%0d", c), 64'(bus.resp_valid), 64'd1);
      chk($sformatf("bp_sum%0d", c), bus.resp_sum, 64'd7);
      chk($sformatf("bp_rid%0d", c), 64'(bus.resp_id), 64'd1);
      chk($sformatf("bp_cout%0d", c), 64'(bus.resp_cout), 64'd0);
      chk($sformatf("bp_ready%0d", c), 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    #1 chk("bp_grant2", 64'(bus.req_ready), 64'b0100);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    chk("bp_opcnt", 64'(op_count), 64'd6);
    @(posedge clk); #1;
    chk("bp2_rid", 64'(bus.resp_id), 64'd2);
    chk("bp2_sum", bus.resp_sum, 64'd30);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;

    // Chained grant in the same cycle the carry-producing result is accepted
    @(negedge clk);
    clear_req();
    bus.req_valid[2] = 1'b1;
    bus.req_a[64*2 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.req_b[64*2 +: 64] = 64'd1;
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    chk("byp_cout1", 64'(bus.resp_cout), 64'd1);
    bus.req_valid[2] = 1'b1;
    bus.req_chain[2] = 1'b1;
    bus.req_a[64*2 +: 64] = 64'd0;
    bus.req_b[64*2 +: 64] = 64'd0;
    bus.resp_ready = 1'b1;
    #1 chk("byp_grant", 64'(bus.req_ready), 64'b0100);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    chk("byp_xin", 64'(add_xin), 64'h67);
    @(posedge clk); #1;
    chk("byp_sum", bus.resp_sum, 64'd1);
    chk("byp_cout2", 64'(bus.resp_cout), 64'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("byp_opcnt", 64'(op_count), 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
